// File: rtl/seq_divider_8bit_pkg.sv
// Shared arithmetic-library definitions: divider FSM states, default width, counter sizing.
// Optional build macro affecting users of this package: SEQ_DIVIDER_SIGNED_EN.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Request/result bundle for the sequential divider.
// Handshake: start is honoured only while the divider is idle or in its done cycle;
// operands are captured on that edge, busy is high while iterating, done pulses for
// one cycle when quotient/remainder/div_by_zero become valid, and those stay held.
interface seq_divider_8bit_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8bit_div_addsub_stage.sv
// Combinational N-bit adder/subtractor: sub_i inverts b_i and supplies the carry-in.
module div_addsub_stage #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o
);
    assign sum_o = a_i + (b_i ^ {N{sub_i}}) + {{(N-1){1'b0}}, sub_i};
endmodule

// File: rtl/seq_divider_8bit.sv
// Restoring sequential divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider_8bit
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_divider_8bit_if.slave  bus,
    output state_e             dbg_state_o
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_res;
    logic [WIDTH-1:0] rem_res;
    logic             accept;

    // The partial remainder is always below the divisor, so its (WIDTH+1)th bit
    // is never set between iterations; only the shifted trial value needs it.
    assign shifted = {r_q, q_q[WIDTH-1]};

    div_addsub_stage #(.N(WIDTH + 1)) u_iter (
        .a_i   (shifted),
        .b_i   ({1'b0, d_q}),
        .sub_i (1'b1),
        .sum_o (diff)
    );

    assign fits   = ~diff[WIDTH];
    assign r_nxt  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign q_nxt  = {q_q[WIDTH-2:0], fits};
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] dvd_neg;
    logic [WIDTH-1:0] dvs_neg;
    logic [WIDTH-1:0] quot_neg;
    logic [WIDTH-1:0] rem_neg;

    div_addsub_stage #(.N(WIDTH)) u_neg_dvd (
        .a_i('0), .b_i(bus.dividend), .sub_i(1'b1), .sum_o(dvd_neg));
    div_addsub_stage #(.N(WIDTH)) u_neg_dvs (
        .a_i('0), .b_i(bus.divisor), .sub_i(1'b1), .sum_o(dvs_neg));
    div_addsub_stage #(.N(WIDTH)) u_neg_quot (
        .a_i('0), .b_i(q_nxt), .sub_i(1'b1), .sum_o(quot_neg));
    div_addsub_stage #(.N(WIDTH)) u_neg_rem (
        .a_i('0), .b_i(r_nxt), .sub_i(1'b1), .sum_o(rem_neg));

    // The most-negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign dvd_mag  = bus.dividend[WIDTH-1] ? dvd_neg : bus.dividend;
    assign dvs_mag  = bus.divisor[WIDTH-1]  ? dvs_neg : bus.divisor;
    assign quot_res = neg_quot_q ? quot_neg : q_nxt;
    assign rem_res  = neg_rem_q  ? rem_neg  : r_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            neg_quot_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_q  <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag  = bus.dividend;
    assign dvs_mag  = bus.divisor;
    assign quot_res = q_nxt;
    assign rem_res  = r_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        r_q   <= '0;
                        d_q   <= dvs_mag;
                        dbz_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            // Raw dividend is parked in q_q; it becomes the remainder.
                            q_q     <= bus.dividend;
                            state_q <= ZERO;
                        end else begin
                            q_q     <= dvd_mag;
                            cnt_q   <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    r_q   <= r_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quot_q  <= quot_res;
                        rem_q   <= rem_res;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                ZERO: begin
                    quot_q  <= '1;
                    rem_q   <= q_q;
                    dbz_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state_o     = state_q;

endmodule
